// File: rtl/led_cursor_ctrl.sv
// Cursor controller for the board LED banks: four debounced buttons move a one-hot cursor across
// WIDTH positions and NCH colour channels. Define AUTO_REPEAT_EN to enable hold-to-repeat on left/right.
module led_cursor_ctrl #(
  parameter int WIDTH           = 4,
  parameter int NCH             = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  localparam int PW = $clog2(WIDTH),
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             button,
  output logic [NCH*WIDTH-1:0]   led,
  output logic [PW-1:0]          pos,
  output logic [CW-1:0]          chan,
  output logic                   move_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
  localparam logic [CW-1:0] CHAN_MAX = CW'(NCH - 1);
  localparam logic [NCH*WIDTH-1:0] LED_ONE = {{(NCH*WIDTH-1){1'b0}}, 1'b1};

  logic [3:0]    sync1, sync2, db, db_d, ev;
  logic [DW-1:0] db_cnt [4];

  // Debounced state flips only after the synced level has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      ev    <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      db_d  <= db;
      ev    <= db & ~db_d;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  logic rep_r, rep_l;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);

  logic [RW-1:0] rep_cnt;
  logic          rep_phase;
  logic          one_held, rep_fire;

  // rep_cnt==0 means idle; only a fresh press event arms it.
  assign one_held = db[0] ^ db[3];
  assign rep_fire = one_held && (rep_cnt == (rep_phase ? R_PERIOD : R_DELAY));
  assign rep_r    = rep_fire & db[0];
  assign rep_l    = rep_fire & db[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (!one_held) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (ev[0] | ev[3]) begin
      rep_cnt   <= RW'(1);
      rep_phase <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= RW'(1);
      rep_phase <= 1'b1;
    end else if (rep_cnt != '0) begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  logic unused_rep;
  assign unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_r = 1'b0;
  assign rep_l = 1'b0;
`endif

  logic                 mv_r, mv_l, mv_n, mv_p;
  logic [PW-1:0]        pos_nxt;
  logic [CW-1:0]        chan_nxt;
  logic [NCH*WIDTH-1:0] led_nxt;

  assign mv_r = ev[0] | rep_r;
  assign mv_l = ev[3] | rep_l;
  assign mv_n = ev[2];
  assign mv_p = ev[1];

  always_comb begin
    pos_nxt  = pos;
    chan_nxt = chan;
    if (mv_r && !mv_l) pos_nxt = (pos == '0) ? POS_MAX : pos - 1'b1;
    if (mv_l && !mv_r) pos_nxt = (pos == POS_MAX) ? '0 : pos + 1'b1;
    if (NCH > 1) begin
      if (mv_n && !mv_p) chan_nxt = (chan == CHAN_MAX) ? '0 : chan + 1'b1;
      if (mv_p && !mv_n) chan_nxt = (chan == '0) ? CHAN_MAX : chan - 1'b1;
    end
    led_nxt = LED_ONE << (int'(chan_nxt) * WIDTH + int'(pos_nxt));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos        <= '0;
      chan       <= '0;
      led        <= LED_ONE;
      move_pulse <= 1'b0;
    end else begin
      pos        <= pos_nxt;
      chan       <= chan_nxt;
      led        <= led_nxt;
      move_pulse <= (pos_nxt != pos) || (chan_nxt != chan);
    end
  end

endmodule
